bcd_digit_seq: RTL and testbench
================================

Name: bcd_digit_seq

Overview:
- Multi-digit BCD up-counter built around one shared single-digit incrementer (4-bit in, BCD digit+1 out).
- Controller time-shares the incrementer across NDIG digits, one digit per clock, rippling the carry from the least-significant digit upward.
- Sits between event sources (pulse counters, display front-ends) and the BCD display/readout path. Trades latency for a single incrementer instance.

Parameters:
- NDIG, 4, number of BCD digits; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inc_valid  input  1  increment request.
- inc_ready  output  1  controller can accept a request.
- clr  input  1  synchronous clear, highest priority.
- load_en  input  1  load count from load_val; honoured only when idle.
- load_val  input  4*NDIG  value to load; digit i is bits [4i+3:4i].
- count  output  4*NDIG  current BCD count, registered.
- done  output  1  one-cycle pulse when an increment completes.
- overflow  output  1  one-cycle pulse, coincident with done, when the count wraps all-9s -> all-0s.

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, done=0, overflow=0, inc_ready=1, state=IDLE, digit index idx=0.
- FSM states: IDLE, RIPPLE.
  - IDLE: inc_ready=1.
    - On inc_valid & inc_ready: go to RIPPLE with idx=0.
    - Else if load_en: count<=load_val, stay IDLE.
    - If inc_valid and load_en are both high, the increment wins and the load is ignored.
  - RIPPLE: inc_ready=0.
    - Each cycle, the incrementer input is digit[idx].
    - If digit[idx] >= 9: write 0 and carry. Any value 10..15 (only reachable via load) is treated as 9.
    - Else: write digit[idx]+1, no carry.
    - Carry and idx<NDIG-1: idx<=idx+1, stay RIPPLE.
    - No carry: go to IDLE, done=1 next cycle.
    - Carry and idx==NDIG-1: go to IDLE, done=1 and overflow=1 next cycle.
- Latency:
  - Request accepted at edge E0. Digit 0 is written at E1.
  - With k digits touched (1..NDIG), the last digit is written at Ek. done is high for the cycle after Ek.
  - inc_ready is low for exactly k cycles and high again in the same cycle as done.
  - A new request may be accepted in the done cycle, giving back-to-back throughput of one increment per k+1 cycles.
- Only the digit at idx changes in a given cycle; other digits hold. Intermediate counts are visible on count during RIPPLE. Consumers sample count on done.
- clr: in any state, next edge sets count=0, state=IDLE, idx=0, done=0, overflow=0. An in-flight ripple is aborted with no done. clr overrides inc_valid and load_en in the same cycle.
- load_en during RIPPLE is ignored.
- inc_valid held high is a new request each time inc_ready is high. inc_valid while inc_ready=0 is not captured; the requester must hold it.
- Reset asserted mid-ripple: immediate return to the reset values above; the partial increment is discarded.
- NDIG=1: every increment touches 1 digit; overflow on 9->0.

Optional Feature:
- Macro BCD_SATURATE_EN.
- Defined: when all digits are 9 (or >=9), an accepted increment leaves count unchanged. The controller spends exactly 1 RIPPLE cycle with no digit writes, then pulses done with overflow=1.
- Undefined: count wraps to all-0s as described above.

Test Plan:
- Reset with rst_n=0 mid-ripple from count 0x0999 -> count=0x0000, inc_ready=1, no done.
- Count 0x0000, one increment -> count=0x0001, inc_ready low 1 cycle, done 1 cycle after accept+1, overflow=0.
- Load 0x0199, increment -> digits update over 3 cycles to 0x0200; done after third write; inc_ready low 3 cycles.
- Load 0x9999, increment -> count=0x0000 after 4 cycles, done=overflow=1. With BCD_SATURATE_EN -> count stays 0x9999, done=overflow=1 after 1 cycle.
- Load 0x000F (illegal digit), increment -> count=0x0010, done after 2 cycles.
- Load 0x0999, increment, assert clr in the 2nd RIPPLE cycle -> count=0x0000 next edge, no done; simultaneous inc_valid+load_en in IDLE -> increment applied, load ignored.

Source files
------------

// File: rtl/bcd_digit_seq_if.sv
// Request/status bundle for bcd_digit_seq: increment handshake, clear, load and the BCD count.
// master = event source / readout side, slave = the counter itself.
interface bcd_digit_seq_if #(
  parameter int NDIG = 4
);
  logic              inc_valid;
  logic              inc_ready;
  logic              clr;
  logic              load_en;
  logic [4*NDIG-1:0] load_val;
  logic [4*NDIG-1:0] count;
  logic              done;
  logic              overflow;

  modport master (
    output inc_valid, clr, load_en, load_val,
    input  inc_ready, count, done, overflow
  );

  modport slave (
    input  inc_valid, clr, load_en, load_val,
    output inc_ready, count, done, overflow
  );
endinterface

// File: rtl/bcd_digit_seq.sv
// Multi-digit BCD up-counter sharing one single-digit incrementer, rippling one digit per clock.
// Optional build macro BCD_SATURATE_EN: an increment of an all-9s count holds the count instead of wrapping.
module bcd_digit_seq #(
  parameter int NDIG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_digit_seq_if.slave  bus
);

  localparam int CW    = 4 * NDIG;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

`ifdef BCD_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    RIPPLE
  } state_t;

  // Shared incrementer: {carry, digit}; 10..15 can only arrive via load and behave like 9.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d);
    if (d >= 4'd9) return 5'b1_0000;
    return {1'b0, d + 4'd1};
  endfunction

  function automatic logic all_nines(input logic [CW-1:0] c);
    for (int i = 0; i < NDIG; i++) begin
      if (c[4*i +: 4] < 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              inc_ready_q, inc_ready_d;
  logic [3:0]        cur_digit;
  logic [4:0]        inc_res;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    done_d      = 1'b0;
    overflow_d  = 1'b0;
    inc_ready_d = inc_ready_q;
    cur_digit   = count_q[int'(idx_q)*4 +: 4];
    inc_res     = bcd_inc(cur_digit);

    if (bus.clr) begin
      state_d     = IDLE;
      idx_d       = '0;
      count_d     = '0;
      inc_ready_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.inc_valid && inc_ready_q) begin
            state_d     = RIPPLE;
            idx_d       = '0;
            inc_ready_d = 1'b0;
          end else if (bus.load_en) begin
            count_d = bus.load_val;
          end
        end

        RIPPLE: begin
          // Saturating build: one idle ripple cycle, no digit writes, then done+overflow.
          if (SAT_EN && (idx_q == '0) && all_nines(count_q)) begin
            state_d     = IDLE;
            idx_d       = '0;
            inc_ready_d = 1'b1;
            done_d      = 1'b1;
            overflow_d  = 1'b1;
          end else begin
            count_d[int'(idx_q)*4 +: 4] = inc_res[3:0];
            if (!inc_res[4]) begin
              state_d     = IDLE;
              idx_d       = '0;
              inc_ready_d = 1'b1;
              done_d      = 1'b1;
            end else if (idx_q == LAST_IDX) begin
              state_d     = IDLE;
              idx_d       = '0;
              inc_ready_d = 1'b1;
              done_d      = 1'b1;
              overflow_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end

        default: begin
          state_d     = IDLE;
          idx_d       = '0;
          inc_ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      inc_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      inc_ready_q <= inc_ready_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;
  assign bus.inc_ready = inc_ready_q;

endmodule

// File: tb/tb_bcd_digit_seq.sv
// Self-checking bench for bcd_digit_seq (NDIG=4): vector table, corner sequences, randomized ops vs integer model.
module tb_bcd_digit_seq;
  localparam int NDIG = 4;
  localparam int MODV = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_digit_seq_if #(.NDIG(NDIG)) bus ();

  bcd_digit_seq #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ld;
    logic [15:0] exp_cnt;
    int          k;
    bit          ov;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int d = 0; d < NDIG; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic do_load(input string nm, input logic [15:0] v);
    bus.load_val = v;
    bus.load_en  = 1'b1;
    step();
    bus.load_en  = 1'b0;
    chk({nm, "_load"}, 32'(bus.count), 32'(v));
  endtask

  // Issue one increment from an idle controller and check the whole transaction.
  task automatic run_inc(input string nm, input logic [15:0] exp_cnt, input int exp_k, input bit exp_ov);
    int cyc;
    int rl;
    bus.inc_valid = 1'b1;
    step();
    bus.inc_valid = 1'b0;
    cyc = 0;
    rl  = 0;
    while (!bus.done && cyc < 40) begin
      if (!bus.inc_ready) rl++;
      step();
      cyc++;
    end
    chk({nm, "_k"}, 32'(cyc), 32'(exp_k));
    chk({nm, "_rdylow"}, 32'(rl), 32'(exp_k));
    chk({nm, "_count"}, 32'(bus.count), 32'(exp_cnt));
    chk({nm, "_ovf"}, 32'(bus.overflow), 32'(exp_ov));
    chk({nm, "_rdy_at_done"}, 32'(bus.inc_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int op;
    int seen_done;
    int t, tr, k_exp;
    bit ov_exp;
    int n_next;

    bus.inc_valid = 1'b0;
    bus.clr       = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_val  = '0;

    vt[0] = '{16'h0000, 16'h0001, 1, 1'b0};
    vt[1] = '{16'h0199, 16'h0200, 3, 1'b0};
`ifdef BCD_SATURATE_EN
    vt[2] = '{16'h9999, 16'h9999, 1, 1'b1};
`else
    vt[2] = '{16'h9999, 16'h0000, 4, 1'b1};
`endif
    vt[3] = '{16'h000F, 16'h0010, 2, 1'b0};
    vt[4] = '{16'h0009, 16'h0010, 2, 1'b0};
    vt[5] = '{16'h0998, 16'h0999, 1, 1'b0};
    vt[6] = '{16'h8999, 16'h9000, 4, 1'b0};

    // Reset values
    repeat (2) step();
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_ready", 32'(bus.inc_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    step();

    // Async reset mid-ripple from 0x0999
    do_load("rstmid", 16'h0999);
    bus.inc_valid = 1'b1;
    step();
    bus.inc_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_count", 32'(bus.count), 32'h0);
    chk("rstmid_ready", 32'(bus.inc_ready), 32'd1);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    step();
    rst_n = 1'b1;
    seen_done = 0;
    repeat (5) begin
      step();
      if (bus.done) seen_done++;
    end
    chk("rstmid_nodone", 32'(seen_done), 32'd0);
    chk("rstmid_hold", 32'(bus.count), 32'h0);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      do_load($sformatf("vec%0d", i), vt[i].ld);
      run_inc($sformatf("vec%0d", i), vt[i].exp_cnt, vt[i].k, vt[i].ov);
      step();
      chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
    end

    // clr in the second ripple cycle aborts without done
    do_load("clr", 16'h0999);
    bus.inc_valid = 1'b1;
    step();
    bus.inc_valid = 1'b0;
    step();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    chk("clr_count", 32'(bus.count), 32'h0);
    chk("clr_ready", 32'(bus.inc_ready), 32'd1);
    seen_done = (bus.done) ? 1 : 0;
    repeat (5) begin
      step();
      if (bus.done) seen_done++;
    end
    chk("clr_nodone", 32'(seen_done), 32'd0);
    chk("clr_hold", 32'(bus.count), 32'h0);

    // Simultaneous inc_valid + load_en in IDLE: increment wins
    bus.load_val = 16'h5555;
    bus.load_en  = 1'b1;
    run_inc("inc_beats_load", 16'h0001, 1, 1'b0);
    bus.load_en  = 1'b0;

    // load_en held through a ripple is ignored
    do_load("ldrip", 16'h0199);
    bus.load_val = 16'h7777;
    bus.load_en  = 1'b1;
    run_inc("ldrip", 16'h0200, 3, 1'b0);
    bus.load_en  = 1'b0;

    // clr wins over load_en
    bus.clr      = 1'b1;
    bus.load_en  = 1'b1;
    bus.load_val = 16'h4321;
    step();
    bus.clr      = 1'b0;
    bus.load_en  = 1'b0;
    chk("clr_beats_load", 32'(bus.count), 32'h0);

    // Randomized ops against an integer model
    n = 0;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      if (op < 7) begin
        t  = n;
        tr = 0;
        while ((t % 10) == 9 && tr < NDIG) begin
          tr++;
          t = t / 10;
        end
        ov_exp = (n == MODV - 1);
`ifdef BCD_SATURATE_EN
        if (ov_exp) begin
          k_exp  = 1;
          n_next = n;
        end else begin
          k_exp  = tr + 1;
          n_next = n + 1;
        end
`else
        k_exp  = ov_exp ? NDIG : tr + 1;
        n_next = (n + 1) % MODV;
`endif
        run_inc($sformatf("rnd%0d_inc", it), to_bcd(n_next), k_exp, ov_exp);
        n = n_next;
      end else if (op < 9) begin
        if ($urandom_range(0, 1) == 0) n = int'($urandom_range(0, MODV - 1));
        else n = MODV - 1 - int'($urandom_range(0, 2));
        do_load($sformatf("rnd%0d", it), to_bcd(n));
      end else begin
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        n = 0;
        chk($sformatf("rnd%0d_clr", it), 32'(bus.count), 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
